// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, timeout default.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and zero/sign extension, little-endian.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        signext,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (size)
            SZ_BYTE: data = signext ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            SZ_HALF: data = signext ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one outstanding load/store on a req/ack data port (MEM_TIMEOUT_EN adds bus timeout).
// Latency: 3 cycles minimum per memory op, +1 per extra ack wait; non-memory ops pass through combinationally.
// Backpressure: mem_stall holds the upstream pipeline while a request is being issued or is outstanding.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exmmemread,
    input  logic        exmmemwrite,
    input  logic [1:0]  exmsize,
    input  logic        exmsignext,
    input  logic [31:0] exmaluresult,
    input  logic [31:0] exmwritedata,
    input  logic        exmregwrite,
    input  logic        exmmemtoreg,
    input  logic [4:0]  exmrd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] data,
    output logic        memregwrite,
    output logic        memmemtoreg,
    output logic [31:0] memaluresult,
    output logic [4:0]  memrd,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_buserr
);

    state_t      state, state_nxt;
    logic        memop, misalign, timeout, buserr;
    logic        req_q, we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q, be_nxt;
    logic [31:0] wdata_q, wdata_nxt, rdata_q, aligned;

    assign memop    = exmmemread | exmmemwrite;
    // Size 2'b11 is treated as a word, so any size with bit 1 set needs word alignment.
    assign misalign = memop & (((exmsize == SZ_HALF) & exmaluresult[0]) |
                               (exmsize[1] & (|exmaluresult[1:0])));

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = exmwritedata;
        case (exmsize)
            SZ_BYTE: begin
                be_nxt    = 4'b0001 << exmaluresult[1:0];
                wdata_nxt = {4{exmwritedata[7:0]}};
            end
            SZ_HALF: begin
                be_nxt    = exmaluresult[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{exmwritedata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          buserr_q;

    assign timeout = (state == ST_BUSY) & ~mem_ack & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign buserr  = (state == ST_DONE) & buserr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            buserr_q <= 1'b0;
        end else begin
            tmo_cnt  <= (state == ST_BUSY && state_nxt == ST_BUSY) ? tmo_cnt + 1'b1 : '0;
            buserr_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign buserr  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memop && !misalign) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (mem_ack || timeout) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_BUSY) begin
                req_q   <= 1'b1;
                we_q    <= exmmemwrite;
                addr_q  <= exmaluresult[31:2];
                be_q    <= be_nxt;
                wdata_q <= wdata_nxt;
            end else if (state == ST_BUSY && state_nxt == ST_DONE) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                // A timed-out access returns zero rather than whatever is on the bus.
                rdata_q <= mem_ack ? mem_rdata : '0;
            end
        end
    end

    mem_access_stage_load_align u_load_align (
        .rdata   (rdata_q),
        .offset  (exmaluresult[1:0]),
        .size    (exmsize),
        .signext (exmsignext),
        .data    (aligned)
    );

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = {addr_q, 2'b00};
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;
    assign data         = exmmemread ? aligned : '0;
    assign memregwrite  = exmregwrite & ~misalign & ~buserr;
    assign memmemtoreg  = exmmemtoreg;
    assign memaluresult = exmaluresult;
    assign memrd        = exmrd;
    assign mem_misalign = misalign;
    assign mem_buserr   = buserr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; inputs driven on negedge, outputs sampled 2 time units later.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exmmemread, exmmemwrite, exmsignext, exmregwrite, exmmemtoreg;
    logic [1:0]  exmsize;
    logic [31:0] exmaluresult, exmwritedata;
    logic [4:0]  exmrd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, data, memaluresult;
    logic [3:0]  mem_be;
    logic        memregwrite, memmemtoreg, mem_stall, mem_misalign, mem_buserr;
    logic [4:0]  memrd;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst(rst),
        .exmmemread(exmmemread), .exmmemwrite(exmmemwrite), .exmsize(exmsize),
        .exmsignext(exmsignext), .exmaluresult(exmaluresult), .exmwritedata(exmwritedata),
        .exmregwrite(exmregwrite), .exmmemtoreg(exmmemtoreg), .exmrd(exmrd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .data(data), .memregwrite(memregwrite), .memmemtoreg(memmemtoreg),
        .memaluresult(memaluresult), .memrd(memrd), .mem_stall(mem_stall),
        .mem_misalign(mem_misalign), .mem_buserr(mem_buserr)
    );

    task automatic drive_idle;
        exmmemread = 0; exmmemwrite = 0; exmsize = SZ_WORD; exmsignext = 0;
        exmaluresult = 0; exmwritedata = 0; exmregwrite = 0; exmmemtoreg = 0;
        exmrd = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // Called just after a negedge; leaves the op on the inputs so the caller can chain back-to-back.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int delay, input logic [31:0] exp_data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int stalls, busy;
        logic done, acked;
        logic [31:0] exp;
        exmmemread = rd; exmmemwrite = wr; exmsize = sz; exmsignext = sx;
        exmaluresult = addr; exmwritedata = wd; exmregwrite = rd; exmmemtoreg = rd; exmrd = 5'd7;
        sb_q.push_back(exp_data);
        stalls = 0; busy = 0; done = 0; acked = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #2;
            if (mem_stall) stalls++;
            if (acked) begin
                exp = sb_q.pop_front();
                n_checks++; if (data !== exp) $display("FAIL %s data: got %h want %h", name, data, exp); else n_pass++;
                n_checks++; if (memregwrite !== rd) $display("FAIL %s memregwrite: got %b want %b", name, memregwrite, rd); else n_pass++;
                n_checks++; if (stalls !== delay + 2) $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, delay + 2); else n_pass++;
                n_checks++; if (mem_req !== 1'b0) $display("FAIL %s req_drop: got %b want 0", name, mem_req); else n_pass++;
                done = 1;
            end else if (mem_req) begin
                n_checks++; if (mem_addr !== {addr[31:2], 2'b00}) $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, {addr[31:2], 2'b00}); else n_pass++;
                n_checks++; if (mem_we !== wr) $display("FAIL %s mem_we: got %b want %b", name, mem_we, wr); else n_pass++;
                n_checks++; if (mem_be !== exp_be) $display("FAIL %s mem_be: got %b want %b", name, mem_be, exp_be); else n_pass++;
                if (wr) begin
                    n_checks++; if (mem_wdata !== exp_wdata) $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, exp_wdata); else n_pass++;
                end
                if (busy == delay) begin
                    mem_ack = 1'b1; mem_rdata = rdat; acked = 1;
                end
                busy++;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'h0;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s completion: got none want DONE within cycle budget", name);
            sb_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        exmmemread = 1; exmaluresult = 32'h101;
        repeat (2) @(negedge clk);
        #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (data !== 32'h0) $display("FAIL reset data: got %h want 0", data); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset mem_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_buserr !== 1'b0) $display("FAIL reset mem_buserr: got %b want 0", mem_buserr); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_loads;
        run_op("lw",   1, 0, SZ_WORD, 0, 32'h100, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'b1111, 0);
        run_op("lb",   1, 0, SZ_BYTE, 1, 32'h103, 0, 32'h80000000, 0, 32'hFFFFFF80, 4'b1000, 0);
        run_op("lbu",  1, 0, SZ_BYTE, 0, 32'h103, 0, 32'h80000000, 2, 32'h00000080, 4'b1000, 0);
        run_op("lh",   1, 0, SZ_HALF, 1, 32'h102, 0, 32'h80011234, 0, 32'hFFFF8001, 4'b1100, 0);
        run_op("lhu",  1, 0, SZ_HALF, 0, 32'h100, 0, 32'h8001F234, 1, 32'h0000F234, 4'b0011, 0);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_stores;
        run_op("sh", 0, 1, SZ_HALF, 0, 32'h202, 32'h00001234, 0, 0, 0, 4'b1100, 32'h12341234);
        run_op("sb", 0, 1, SZ_BYTE, 0, 32'h101, 32'hFFFFFFAB, 0, 1, 0, 4'b0010, 32'hABABABAB);
        run_op("sw", 0, 1, SZ_WORD, 0, 32'h104, 32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'hCAFEF00D);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_misalign;
        exmmemread = 1; exmsize = SZ_WORD; exmaluresult = 32'h101; exmregwrite = 1; exmrd = 5'd4;
        #2;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL mis_lw stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_misalign !== 1'b1) $display("FAIL mis_lw misalign: got %b want 1", mem_misalign); else n_pass++;
        n_checks++; if (memregwrite !== 1'b0) $display("FAIL mis_lw memregwrite: got %b want 0", memregwrite); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL mis_lw mem_req: got %b want 0", mem_req); else n_pass++;
        @(negedge clk);
        drive_idle();
        exmmemwrite = 1; exmsize = SZ_HALF; exmaluresult = 32'h203; exmwritedata = 32'h5678;
        #2;
        n_checks++; if (mem_misalign !== 1'b1) $display("FAIL mis_sh misalign: got %b want 1", mem_misalign); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL mis_sh stall: got %b want 0", mem_stall); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL mis_sh mem_req: got %b want 0", mem_req); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_passthrough;
        exmaluresult = 32'h12345671; exmregwrite = 1; exmmemtoreg = 0; exmrd = 5'd19;
        #2;
        n_checks++; if (memaluresult !== 32'h12345671) $display("FAIL pass aluresult: got %h want 12345671", memaluresult); else n_pass++;
        n_checks++; if (memrd !== 5'd19) $display("FAIL pass rd: got %0d want 19", memrd); else n_pass++;
        n_checks++; if (memregwrite !== 1'b1) $display("FAIL pass memregwrite: got %b want 1", memregwrite); else n_pass++;
        n_checks++; if (mem_misalign !== 1'b0) $display("FAIL pass misalign: got %b want 0", mem_misalign); else n_pass++;
        n_checks++; if (data !== 32'h0) $display("FAIL pass data: got %h want 0", data); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL pass stall: got %b want 0", mem_stall); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL pass mem_req: got %b want 0", mem_req); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_busy;
        exmmemread = 1; exmsize = SZ_WORD; exmaluresult = 32'h100; exmregwrite = 1;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rstbusy req_up: got %b want 1", mem_req); else n_pass++;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        // Misaligned word load keeps the stage idle while exposing the captured read data.
        exmmemread = 1; exmaluresult = 32'h101; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rstbusy req_drop: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL rstbusy stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (data !== 32'h0) $display("FAIL rstbusy data: got %h want 0", data); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0;
        #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rstbusy ack_ignored_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (data !== 32'h0) $display("FAIL rstbusy ack_ignored_data: got %h want 0", data); else n_pass++;
        @(negedge clk);
        drive_idle();
        run_op("post_rst_lw", 1, 0, SZ_WORD, 0, 32'h10, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 4'b1111, 0);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_timeout;
`ifdef MEM_TIMEOUT_EN
        int busy;
        logic seen;
        exmmemread = 1; exmsize = SZ_WORD; exmaluresult = 32'h300; exmregwrite = 1; exmrd = 5'd3;
        busy = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #2;
            if (mem_req) busy++;
            else if (busy > 0) begin
                seen = 1;
                n_checks++; if (busy !== 4) $display("FAIL tmo busy_cycles: got %0d want 4", busy); else n_pass++;
                n_checks++; if (mem_buserr !== 1'b1) $display("FAIL tmo buserr: got %b want 1", mem_buserr); else n_pass++;
                n_checks++; if (memregwrite !== 1'b0) $display("FAIL tmo memregwrite: got %b want 0", memregwrite); else n_pass++;
                n_checks++; if (data !== 32'h0) $display("FAIL tmo data: got %h want 0", data); else n_pass++;
                n_checks++; if (mem_stall !== 1'b0) $display("FAIL tmo stall: got %b want 0", mem_stall); else n_pass++;
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL tmo completion: got no timeout want one within cycle budget");
        end
        @(negedge clk);
        drive_idle();
        #2;
        n_checks++; if (mem_buserr !== 1'b0) $display("FAIL tmo buserr_clear: got %b want 0", mem_buserr); else n_pass++;
        @(negedge clk);
`else
        run_op("long_wait", 1, 0, SZ_WORD, 0, 32'h300, 0, 32'h600DCAFE, 70, 32'h600DCAFE, 4'b1111, 0);
        drive_idle();
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back;
        run_op("b2b_lbu", 1, 0, SZ_BYTE, 0, 32'h102, 0, 32'h00A50000, 0, 32'h000000A5, 4'b0100, 0);
        run_op("b2b_sw",  0, 1, SZ_WORD, 0, 32'h108, 32'h01020304, 0, 3, 0, 4'b1111, 32'h01020304);
        run_op("b2b_sz3", 1, 0, 2'b11,   1, 32'h10C, 0, 32'h13572468, 0, 32'h13572468, 4'b1111, 0);
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_passthrough();
        test_reset_busy();
        test_timeout();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
